// File: rtl/gb_serial_link_pkg.sv
// rtl/gb_serial_link_pkg.sv - shared types and constants for the Game Boy link port
package gb_serial_link_pkg;

    // SC register bit positions
    localparam int SC_START = 7;
    localparam int SC_CLK   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN_INT,
        ST_RUN_EXT,
        ST_DONE
    } link_state_t;

    // SC readback: unused bits read as 1
    function automatic logic [7:0] sc_value(input logic start, input logic clk_int);
        return {start, 6'b111111, clk_int};
    endfunction

endpackage

// File: rtl/gb_sync_edge.sv
// rtl/gb_sync_edge.sv - link line synchronisers with clock edge pulses held until the next ce
module gb_sync_edge (
    input  logic clk_sys,
    input  logic reset,
    input  logic ce,
    input  logic clk_in,
    input  logic data_in,
    output logic data_level,
    output logic clk_rise,
    output logic clk_fall
);

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       rise_hold;
    logic       fall_hold;
    logic       raw_rise;
    logic       raw_fall;

    // two-flop synchronisers plus one history flop; the link lines idle high
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], clk_in};
            data_sync <= {data_sync[0], data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    assign raw_rise = clk_sync[1] & ~clk_prev;
    assign raw_fall = ~clk_sync[1] & clk_prev;

    // remember edges seen on non-ce cycles so the next ce cycle still sees them
    always_ff @(posedge clk_sys) begin
        if (reset || ce) begin
            rise_hold <= 1'b0;
            fall_hold <= 1'b0;
        end else begin
            if (raw_rise) rise_hold <= 1'b1;
            if (raw_fall) fall_hold <= 1'b1;
        end
    end

    assign clk_rise   = rise_hold | raw_rise;
    assign clk_fall   = fall_hold | raw_fall;
    assign data_level = data_sync[1];

endmodule

// File: rtl/gb_serial_link.sv
// rtl/gb_serial_link.sv - Game Boy serial link port (SB/SC) with internal and external clocking
module gb_serial_link #(
    parameter int         CLK_DIV  = 512,
    parameter logic [7:0] SB_RESET = 8'h00
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic       sel_sb,
    input  logic       sel_sc,
    input  logic       cpu_wr,
    input  logic [7:0] cpu_di,
    output logic [7:0] sb_do,
    output logic [7:0] sc_do,
    output logic       irq,
    input  logic       ser_clk_in,
    input  logic       ser_data_in,
    output logic       ser_clk_out,
    output logic       ser_data_out
);
    import gb_serial_link_pkg::*;

    localparam int          DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    link_state_t   state;
    logic [7:0]    sb;
    logic          start;
    logic          clk_int;
    logic [DW-1:0] div;
    logic [3:0]    bit_cnt;
    logic          data_s;
    logic          ext_rise;
    logic          ext_fall;
    logic          wr_sb;
    logic          wr_sc;

    gb_sync_edge u_sync (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ce         (ce),
        .clk_in     (ser_clk_in),
        .data_in    (ser_data_in),
        .data_level (data_s),
        .clk_rise   (ext_rise),
        .clk_fall   (ext_fall)
    );

    assign wr_sb = cpu_wr & sel_sb;
    assign wr_sc = cpu_wr & sel_sc;
    assign sb_do = sb;
    assign sc_do = sc_value(start, clk_int);

    // transfer FSM, bit timing, shift register and CPU register writes
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state        <= ST_IDLE;
            sb           <= SB_RESET;
            start        <= 1'b0;
            clk_int      <= 1'b0;
            div          <= '0;
            bit_cnt      <= '0;
            irq          <= 1'b0;
            ser_clk_out  <= 1'b1;
            ser_data_out <= 1'b1;
        end else if (ce) begin
            // irq stays up until the next ce so the flag logic sees it exactly once
            irq <= 1'b0;
            case (state)
                ST_IDLE: ;
                ST_RUN_INT: begin
                    if (div == '0) begin
                        ser_clk_out  <= 1'b0;
                        ser_data_out <= sb[7];
                    end
                    if (div == DIV_HALF) begin
                        ser_clk_out <= 1'b1;
                        sb          <= {sb[6:0], data_s};
                        bit_cnt     <= bit_cnt + 4'd1;
                    end
                    // completion waits for the end of the 8th bit period
                    if (div == DIV_LAST) begin
                        div <= '0;
                        if (bit_cnt == 4'd8) begin
                            state <= ST_DONE;
                            start <= 1'b0;
                            irq   <= 1'b1;
                        end
                    end else begin
                        div <= div + DW'(1);
                    end
                end
                ST_RUN_EXT: begin
                    if (ext_fall) begin
                        ser_data_out <= sb[7];
                    end
                    if (ext_rise) begin
                        sb      <= {sb[6:0], data_s};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state <= ST_DONE;
                            start <= 1'b0;
                            irq   <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    ser_clk_out <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase

            // CPU writes take priority over the shift on the same cycle
            if (wr_sb) begin
                sb <= cpu_di;
            end
            if (wr_sc) begin
                clk_int <= cpu_di[SC_CLK];
                if (cpu_di[SC_START]) begin
                    start       <= 1'b1;
                    div         <= '0;
                    bit_cnt     <= '0;
                    irq         <= 1'b0;
                    ser_clk_out <= 1'b1;
                    state       <= cpu_di[SC_CLK] ? ST_RUN_INT : ST_RUN_EXT;
                end else begin
                    start <= 1'b0;
                    if (state == ST_RUN_INT || state == ST_RUN_EXT) begin
                        state       <= ST_IDLE;
                        ser_clk_out <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gb_serial_link.sv
// tb/tb_gb_serial_link.sv - self-checking bench for gb_serial_link
module tb_gb_serial_link;

    localparam int D = 64;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       ce;
    logic       sel_sb;
    logic       sel_sc;
    logic       cpu_wr;
    logic [7:0] cpu_di;
    logic [7:0] sb_do;
    logic [7:0] sc_do;
    logic       irq;
    logic       ser_clk_in;
    logic       ser_data_in;
    logic       ser_clk_out;
    logic       ser_data_out;

    int   ntests  = 0;
    int   nfail   = 0;
    int   irq_cnt = 0;
    logic irq_q   = 1'b0;

    always #5 clk_sys = ~clk_sys;

    gb_serial_link #(
        .CLK_DIV  (D),
        .SB_RESET (8'h00)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ce           (ce),
        .sel_sb       (sel_sb),
        .sel_sc       (sel_sc),
        .cpu_wr       (cpu_wr),
        .cpu_di       (cpu_di),
        .sb_do        (sb_do),
        .sc_do        (sc_do),
        .irq          (irq),
        .ser_clk_in   (ser_clk_in),
        .ser_data_in  (ser_data_in),
        .ser_clk_out  (ser_clk_out),
        .ser_data_out (ser_data_out)
    );

    // count irq pulses by their rising edge
    always @(negedge clk_sys) begin
        if (irq && !irq_q) irq_cnt++;
        irq_q = irq;
    end

    task automatic cyc();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input bit is_sc, input logic [7:0] v);
        ce     = 1'b1;
        sel_sb = !is_sc;
        sel_sc = is_sc;
        cpu_wr = 1'b1;
        cpu_di = v;
        cyc();
        sel_sb = 1'b0;
        sel_sc = 1'b0;
        cpu_wr = 1'b0;
    endtask

    // internal-clock transfer; the bench plays the peer (fixed byte or loopback)
    task automatic run_int(input logic [7:0] sb_v, input logic [7:0] peer,
                           input bit loopback, input bit gaps, input string tag);
        logic [7:0] outb;
        logic [7:0] pb;
        logic       prev;
        int         k;
        int         first;
        int         guard;
        int         base;
        outb  = 8'h00;
        pb    = peer;
        k     = 0;
        first = -1;
        guard = 0;
        wr(1'b0, sb_v);
        base = irq_cnt;
        wr(1'b1, 8'h81);
        prev = ser_clk_out;
        while (k < 8 * D + 4 && guard < 40 * D) begin
            ce = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            cyc();
            guard++;
            if (ce) k++;
            if (prev && !ser_clk_out) begin
                outb        = {outb[6:0], ser_data_out};
                ser_data_in = loopback ? ser_data_out : pb[7];
                pb          = {pb[6:0], 1'b1};
            end
            prev = ser_clk_out;
            if (irq && first < 0) first = k;
        end
        ce = 1'b1;
        ser_data_in = 1'b1;
        check({tag, "_irq_at"}, first, 8 * D);
        check({tag, "_bits_out"}, outb, sb_v);
        check({tag, "_sb"}, sb_do, loopback ? sb_v : peer);
        check({tag, "_sc"}, sc_do, 8'h7F);
        check({tag, "_irq_count"}, irq_cnt - base, 1);
        check({tag, "_clk_idle"}, ser_clk_out, 1'b1);
    endtask

    task automatic ext_cycles(input int n, input bit gaps);
        for (int j = 0; j < n; j++) begin
            ce = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            cyc();
        end
        ce = 1'b1;
    endtask

    // external-clock transfer; the bench drives the link clock as the master peer
    task automatic run_ext(input logic [7:0] sb_v, input logic [7:0] peer,
                           input bit gaps, input string tag);
        logic [7:0] outb;
        logic [7:0] pb;
        int         base;
        outb = 8'h00;
        pb   = peer;
        wr(1'b0, sb_v);
        base = irq_cnt;
        wr(1'b1, 8'h80);
        for (int i = 0; i < 8; i++) begin
            ser_clk_in  = 1'b0;
            ser_data_in = pb[7];
            pb          = {pb[6:0], 1'b1};
            ext_cycles(32, gaps);
            outb       = {outb[6:0], ser_data_out};
            ser_clk_in = 1'b1;
            ext_cycles(32, gaps);
        end
        ext_cycles(8, 1'b0);
        ser_data_in = 1'b1;
        check({tag, "_bits_out"}, outb, sb_v);
        check({tag, "_sb"}, sb_do, peer);
        check({tag, "_sc"}, sc_do, 8'h7E);
        check({tag, "_irq_count"}, irq_cnt - base, 1);
    endtask

    initial begin
        logic [7:0] last_peer;
        logic [7:0] rv;
        logic       prev;
        int         rises;
        int         guard;
        int         base;

        reset       = 1'b1;
        ce          = 1'b1;
        sel_sb      = 1'b0;
        sel_sc      = 1'b0;
        cpu_wr      = 1'b0;
        cpu_di      = 8'h00;
        ser_clk_in  = 1'b1;
        ser_data_in = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        check("reset_sb", sb_do, 8'h00);
        check("reset_sc", sc_do, 8'h7E);
        check("reset_irq", irq, 1'b0);
        check("reset_clk_out", ser_clk_out, 1'b1);
        check("reset_data_out", ser_data_out, 1'b1);

        run_int(8'hA5, 8'hFF, 1'b0, 1'b0, "int_a5");
        run_int(8'h3C, 8'h00, 1'b1, 1'b0, "loop_3c");
        for (int i = 0; i < 3; i++) begin
            run_int(8'($urandom), 8'($urandom), 1'b0, 1'b1, "int_rnd");
        end

        run_ext(8'h00, 8'h5A, 1'b0, "ext_5a");
        last_peer = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            rv        = 8'($urandom);
            last_peer = 8'($urandom);
            run_ext(rv, last_peer, 1'b1, "ext_rnd");
        end

        // external clock edges while idle must not shift
        base = irq_cnt;
        ser_data_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ser_clk_in = 1'b0;
            ext_cycles(16, 1'b0);
            ser_clk_in = 1'b1;
            ext_cycles(16, 1'b0);
        end
        ser_data_in = 1'b1;
        check("idle_ext_sb", sb_do, last_peer);
        check("idle_ext_irq", irq_cnt - base, 0);

        // abort after three bits
        wr(1'b0, 8'h00);
        wr(1'b1, 8'h81);
        rises = 0;
        guard = 0;
        prev  = ser_clk_out;
        while (rises < 3 && guard < 8 * D) begin
            cyc();
            guard++;
            if (!prev && ser_clk_out) rises++;
            prev = ser_clk_out;
        end
        check("abort_rises", rises, 3);
        base = irq_cnt;
        wr(1'b1, 8'h01);
        repeat (16 * D) cyc();
        check("abort_irq", irq_cnt - base, 0);
        check("abort_clk_out", ser_clk_out, 1'b1);
        check("abort_sc", sc_do, 8'h7F);
        check("abort_partial_sb", sb_do, 8'h07);
        run_int(8'hC3, 8'hFF, 1'b0, 1'b0, "rerun");

        // restart mid-transfer: only the second start completes
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h81);
        repeat (3 * D) cyc();
        run_int(8'h6B, 8'h94, 1'b0, 1'b0, "restart");

        // reset in the middle of bit 5 with the link clock low
        wr(1'b0, 8'h5A);
        wr(1'b1, 8'h81);
        rises = 0;
        guard = 0;
        prev  = ser_clk_out;
        while (!(rises == 4 && !ser_clk_out) && guard < 8 * D) begin
            cyc();
            guard++;
            if (!prev && ser_clk_out) rises++;
            prev = ser_clk_out;
        end
        check("midreset_reached", {rises[7:0], ser_clk_out}, {8'd4, 1'b0});
        base  = irq_cnt;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midreset_sb", sb_do, 8'h00);
        check("midreset_sc", sc_do, 8'h7E);
        check("midreset_irq", irq, 1'b0);
        check("midreset_clk_out", ser_clk_out, 1'b1);
        check("midreset_data_out", ser_data_out, 1'b1);
        repeat (10 * D) cyc();
        check("midreset_no_irq", irq_cnt - base, 0);

        // SB write on the same ce as the first rising edge
        wr(1'b0, 8'h00);
        wr(1'b1, 8'h81);
        repeat (D / 2) cyc();
        wr(1'b0, 8'h96);
        check("collide_rise", ser_clk_out, 1'b1);
        check("collide_sb", sb_do, 8'h96);
        wr(1'b1, 8'h00);
        cyc();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
